// File: rtl/plot_arb_pkg.sv
// Shared types and default geometry for the framebuffer write-port arbiter.
package plot_arb_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } arb_state_t;

    localparam int unsigned PLOT_X_W   = 8;
    localparam int unsigned PLOT_Y_W   = 7;
    localparam int unsigned PLOT_COL_W = 3;
    localparam int unsigned BC_W       = 16;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

endpackage

// File: rtl/plot_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_winner, wrapping.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_winner,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int unsigned cand;
        cand   = 0;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = (32'(last_winner) + i) % N;
            if (!any && req[IW'(cand)]) begin
                any    = 1'b1;
                idx    = IW'(cand);
                onehot = N'(1) << cand;
            end
        end
    end

endmodule

// File: rtl/plot_port_arbiter.sv
// Round-robin arbiter sharing the VGA framebuffer write port among N_REQ draw engines.
// Optional forced release of a stalled burst when PLOT_ARB_TIMEOUT_EN is defined.
module plot_port_arbiter
    import plot_arb_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned X_W         = PLOT_X_W,
    parameter int unsigned Y_W         = PLOT_Y_W,
    parameter int unsigned COL_W       = PLOT_COL_W,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       pix_valid,
    input  logic [N_REQ-1:0]       pix_last,
    input  logic [N_REQ*X_W-1:0]   pix_x,
    input  logic [N_REQ*Y_W-1:0]   pix_y,
    input  logic [N_REQ*COL_W-1:0] pix_colour,
    output logic [N_REQ-1:0]       grant,
    output logic [X_W-1:0]         vga_x,
    output logic [Y_W-1:0]         vga_y,
    output logic [COL_W-1:0]       vga_colour,
    output logic                   vga_plot,
    output logic                   busy,
    output logic [BC_W-1:0]        burst_count,
    output logic                   timeout_err
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    arb_state_t        state;
    logic [IDX_W-1:0]  last_winner;
    logic [N_REQ-1:0]  pick_onehot;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;

    logic [X_W-1:0]    eng_x   [N_REQ];
    logic [Y_W-1:0]    eng_y   [N_REQ];
    logic [COL_W-1:0]  eng_col [N_REQ];
    logic              cur_valid;
    logic              cur_last;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign eng_x[i]   = pix_x[i*X_W +: X_W];
        assign eng_y[i]   = pix_y[i*Y_W +: Y_W];
        assign eng_col[i] = pix_colour[i*COL_W +: COL_W];
    end

    // last_winner doubles as the granted index while a burst is open
    assign cur_valid = pix_valid[last_winner];
    assign cur_last  = pix_last[last_winner];
    assign busy      = (state == S_BURST);

    rr_pick #(.N(N_REQ), .IW(IDX_W)) u_pick (
        .req         (req),
        .last_winner (last_winner),
        .onehot      (pick_onehot),
        .idx         (pick_idx),
        .any         (pick_any)
    );

`ifdef PLOT_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] idle_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            last_winner <= IDX_W'(N_REQ - 1);
            grant       <= '0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= '0;
            vga_plot    <= 1'b0;
            burst_count <= '0;
`ifdef PLOT_ARB_TIMEOUT_EN
            idle_cnt    <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            vga_plot <= 1'b0;
`ifdef PLOT_ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (pick_any) begin
                        grant       <= pick_onehot;
                        last_winner <= pick_idx;
                        burst_count <= '0;
                        state       <= S_BURST;
`ifdef PLOT_ARB_TIMEOUT_EN
                        idle_cnt    <= '0;
`endif
                    end
                end
                S_BURST: begin
                    if (cur_valid) begin
                        vga_x      <= eng_x[last_winner];
                        vga_y      <= eng_y[last_winner];
                        vga_colour <= eng_col[last_winner];
                        vga_plot   <= 1'b1;
                        if (burst_count != '1) begin
                            burst_count <= burst_count + BC_W'(1);
                        end
`ifdef PLOT_ARB_TIMEOUT_EN
                        idle_cnt <= '0;
`endif
                        if (cur_last) begin
                            grant <= '0;
                            state <= S_IDLE;
                        end
                    end
`ifdef PLOT_ARB_TIMEOUT_EN
                    // hung engine keeps last_winner, so it drops to the back of the rotation
                    else if (idle_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        grant       <= '0;
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + TO_W'(1);
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
